mux_rr_stream: RTL and testbench

MUX_RR_STREAM -- requirements
Module: mux_rr_stream

---
 rtl/mux_rr_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/mux_rr_stream.sv | 118 +++++++++++
 tb/tb_mux_rr_stream.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_rr_pkg.sv
// Shared constants and the channel-index width helper for the round-robin stream mux.
package mux_rr_pkg;

  localparam int DEFAULT_WIDTH  = 3;
  localparam int DEFAULT_NUM_IN = 2;

  // ceil(log2(n)), at least 1 so a two-channel mux still gets a one-bit index
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: the first requester at or after ptr (wrapping) wins.
module rr_arbiter
  import mux_rr_pkg::*;
#(
  parameter int NUM_IN = DEFAULT_NUM_IN,
  parameter int SEL_W  = clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_IN-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx
);

  logic found_s;

  // scan channels in priority order starting at ptr
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      int idx;
      idx = (int'(ptr) + i) % NUM_IN;
      if (!found_s && req[idx]) begin
        found_s    = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = SEL_W'(idx);
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/mux_rr_stream.sv
// Round-robin N:1 stream mux with a one-entry registered output stage.
// Optional packet locking is enabled by defining MUX_RR_STREAM_PKT_LOCK_EN.
module mux_rr_stream
  import mux_rr_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NUM_IN = DEFAULT_NUM_IN,
  parameter int SEL_W  = clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN-1:0]       in_last,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [SEL_W-1:0]  ptr_r;
  logic [NUM_IN-1:0] req_s;
  logic [NUM_IN-1:0] grant_s;
  logic [SEL_W-1:0]  grant_idx_s;
  logic              load_en_s;
  logic              xfer_s;
  logic [WIDTH-1:0]  sel_data_s;
  logic [SEL_W-1:0]  ptr_next_s;

`ifdef MUX_RR_STREAM_PKT_LOCK_EN
  logic              lock_r;
  logic [SEL_W-1:0]  lock_ch_r;

  // while a packet is open only its owner may request
  always_comb begin
    req_s = in_valid;
    if (lock_r) begin
      req_s = in_valid & (NUM_IN'(1) << lock_ch_r);
    end else begin
      req_s = in_valid;
    end
  end
`else
  assign req_s = in_valid;
`endif

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_arb (
    .req       (req_s),
    .ptr       (ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  assign load_en_s  = !out_valid || out_ready;
  assign xfer_s     = |in_ready;
  assign sel_data_s = in_data[int'(grant_idx_s)*WIDTH +: WIDTH];

  // ready is the grant, gated by output space and held low during reset
  always_comb begin
    in_ready = '0;
    if (!reset && load_en_s) begin
      in_ready = grant_s;
    end else begin
      in_ready = '0;
    end
  end

  // pointer moves to the channel after the winner, wrapping at NUM_IN
  always_comb begin
    ptr_next_s = '0;
    if (grant_idx_s == SEL_W'(NUM_IN - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = grant_idx_s + SEL_W'(1);
    end
  end

  // output register, pointer and lock state
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr_r     <= '0;
`ifdef MUX_RR_STREAM_PKT_LOCK_EN
      lock_r    <= 1'b0;
      lock_ch_r <= '0;
`endif
    end else if (load_en_s) begin
      out_valid <= xfer_s;
      if (xfer_s) begin
        out_data <= sel_data_s;
        out_sel  <= grant_idx_s;
`ifdef MUX_RR_STREAM_PKT_LOCK_EN
        if (in_last[grant_idx_s]) begin
          lock_r <= 1'b0;
          ptr_r  <= ptr_next_s;
        end else begin
          lock_r    <= 1'b1;
          lock_ch_r <= grant_idx_s;
        end
`else
        ptr_r    <= ptr_next_s;
`endif
      end
    end
  end

`ifndef MUX_RR_STREAM_PKT_LOCK_EN
  logic unused_last_s;
  assign unused_last_s = ^in_last;
`endif

endmodule

// File: tb/tb_mux_rr_stream.sv
// Directed plus randomized bench for mux_rr_stream (NUM_IN=4, WIDTH=8) with a cycle-level reference model.
module tb_mux_rr_stream;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_valid;
  logic           out_ready;

  int checks = 0;
  int fails  = 0;

  // reference model state
  int         m_ptr = 0;
  bit         m_lock = 1'b0;
  int         m_lock_ch = 0;
  bit         m_ov = 1'b0;
  logic [7:0] m_od = 8'd0;
  int         m_os = 0;
  bit         m_rst = 1'b0;

  always #5 clk = ~clk;

  mux_rr_stream #(.WIDTH(W), .NUM_IN(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // who should win this cycle, from the round-robin rule; -1 = nobody
  function automatic int model_grant();
`ifdef MUX_RR_STREAM_PKT_LOCK_EN
    if (m_lock) return in_valid[m_lock_ch] ? m_lock_ch : -1;
`endif
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  // one clock: check ready before the edge, advance the model, check outputs after
  task automatic step();
    int g;
    logic [N-1:0] er;
    #1;
    g  = model_grant();
    er = '0;
    if (!reset && (!m_ov || out_ready) && g >= 0) er[g] = 1'b1;
    chk("in_ready", in_ready, er);
    @(posedge clk);
    if (reset) begin
      m_ov = 0; m_od = 8'd0; m_os = 0; m_ptr = 0; m_lock = 0; m_rst = 1;
    end else begin
      m_rst = 0;
      if (!m_ov || out_ready) begin
        if (g >= 0) begin
          m_ov = 1;
          m_od = in_data[g*W +: W];
          m_os = g;
`ifdef MUX_RR_STREAM_PKT_LOCK_EN
          if (!in_last[g]) begin
            m_lock = 1; m_lock_ch = g;
          end else begin
            m_lock = 0; m_ptr = (g + 1) % N;
          end
`else
          m_ptr = (g + 1) % N;
`endif
        end else begin
          m_ov = 0;
        end
      end
    end
    @(negedge clk);
    chk("out_valid", out_valid, m_ov);
    if (m_ov || m_rst) begin
      chk("out_data", out_data, m_od);
      chk("out_sel", out_sel, m_os);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) step();
    reset = 1'b0;
  endtask

  initial begin
    int exp_lock[4];
    reset     = 1'b1;
    in_data   = 32'h0403_0201;
    in_valid  = 4'b1111;
    in_last   = 4'b1111;
    out_ready = 1'b1;

    // reset with every channel valid
    do_reset(3);
    chk("rst_ready", in_ready, 4'b0000);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_sel", out_sel, 2'd0);
    step();
    chk("rst_first_grant", out_sel, 2'd0);

    // fairness: all valid, no backpressure
    do_reset(1);
    for (int i = 0; i < 8; i++) begin
      in_data = $urandom;
      step();
      chk("fair_valid", out_valid, 1'b1);
      chk("fair_sel", out_sel, 32'(i % N));
    end

    // backpressure holds the beat and blocks every input
    do_reset(1);
    in_valid = 4'b0001;
    in_data  = 32'h0000_0005;
    step();
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = $urandom;
      step();
      chk("bp_data", out_data, 8'd5);
      chk("bp_ready", in_ready, 4'b0000);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = $urandom;
      step();
      chk("bp_resume", out_valid, 1'b1);
    end

    // sparse wrap: ptr=3, only ch1 then only ch0
    do_reset(1);
    in_valid = 4'b0100;
    step();
    in_valid = 4'b0010;
    #1 chk("wrap_ready1", in_ready, 4'b0010);
    step();
    chk("wrap_sel1", out_sel, 2'd1);
    in_valid = 4'b0001;
    step();
    chk("wrap_sel0", out_sel, 2'd0);

    // packet lock on ch2 while ch0 competes
`ifdef MUX_RR_STREAM_PKT_LOCK_EN
    exp_lock = '{2, 2, 2, 0};
`else
    exp_lock = '{2, 0, 2, 0};
`endif
    do_reset(1);
    in_valid = 4'b0010;
    in_last  = 4'b1111;
    step();
    in_valid = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      in_last = (i == 0 || i == 1) ? 4'b1011 : 4'b1111;
      in_data = $urandom;
      step();
      chk("lock_sel", out_sel, 32'(exp_lock[i]));
    end

    // reset in the middle of a locked packet
    do_reset(1);
    in_valid = 4'b0010;
    in_last  = 4'b1111;
    step();
    in_valid = 4'b0101;
    in_last  = 4'b1011;
    step();
    chk("mid_pkt_sel", out_sel, 2'd2);
    do_reset(1);
    in_last = 4'b1111;
    step();
    chk("mid_rst_grant", out_sel, 2'd0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 49) == 0);
      in_valid  = 4'($urandom);
      in_last   = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
